line_doubler_seq: RTL

- Address/control sequencer for the hq2x line RAM: writes each incoming pixel line into one half of a ping-pong buffer while replaying the previous line twice from the other half.
- Output runs at the doubled pixel rate, so the scaler sees every source line repeated.
- Drives the RAM write port, write address and read address; consumes the RAM registered read data, which has 1-clock latency.

---
 rtl/line_doubler_seq.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/line_doubler_seq.sv
// ---------------------------------------------------------------------------
// line_doubler_seq
//   Address/control sequencer for the hq2x line RAM. Each incoming pixel line
//   is written into one half (bank) of a ping-pong line buffer while the
//   previously completed line is replayed twice from the other bank at the
//   doubled output pixel rate.
//
// Ports
//   clock, reset          system clock (rising edge), async active-high reset
//   ce_in, hs_in, de_in   input pixel enable / hsync / data valid
//   pix_in                input pixel
//   ce_out                output pixel enable (2x rate, may be high always)
//   buf_data, buf_wraddress, buf_wren   RAM write port
//   buf_rdaddress         RAM read address
//   buf_q                 RAM registered read data (1 clock latency)
//   pix_out, de_out, hs_out   doubled-line video output
//   line_len              pixel count of the last completed input line
//
// Enable semantics: there is no backpressure. ce_in qualifies every input
// sample (pixels, hsync edge detection); ce_out qualifies every step of the
// read sequencer. A side whose enable is low simply holds its state.
//
// RAM address layout: bit AWIDTH selects the bank, AWIDTH-1:0 the column.
// ---------------------------------------------------------------------------
module line_doubler_seq #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 23,
  parameter int HS_LEN = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce_in,
  input  logic              hs_in,
  input  logic              de_in,
  input  logic [DWIDTH:0]   pix_in,
  input  logic              ce_out,
  output logic [DWIDTH:0]   buf_data,
  output logic [AWIDTH:0]   buf_wraddress,
  output logic              buf_wren,
  output logic [AWIDTH:0]   buf_rdaddress,
  input  logic [DWIDTH:0]   buf_q,
  output logic [DWIDTH:0]   pix_out,
  output logic              de_out,
  output logic              hs_out,
  output logic [AWIDTH:0]   line_len
);

  localparam logic [7:0]      HS_LAST = 8'(HS_LEN - 1);
  localparam logic [AWIDTH:0] COL_ONE = {{AWIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HS     = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Write side
  // -------------------------------------------------------------------------
  // wcol is one bit wider than the column so it can saturate at 2^AWIDTH;
  // its MSB set means the bank is full and further pixels are dropped.
  logic [AWIDTH:0] wcol;
  logic            wbank;
  logic            hs_prev;
  logic            accept;
  logic            line_end;

  assign accept   = ce_in & de_in & ~wcol[AWIDTH];
  assign line_end = ce_in & hs_in & ~hs_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_wren      <= 1'b0;
      buf_data      <= '0;
      buf_wraddress <= '0;
      wcol          <= '0;
      wbank         <= 1'b0;
      hs_prev       <= 1'b0;
      line_len      <= '0;
    end else begin
      buf_wren <= accept;
      if (accept) begin
        buf_data      <= pix_in;
        buf_wraddress <= {wbank, wcol[AWIDTH-1:0]};
      end
      if (ce_in) begin
        hs_prev <= hs_in;
      end
      if (line_end) begin
        // A pixel accepted on the line-end tick still belongs to this line:
        // it lands in the old bank and is included in the count.
        line_len <= wcol + {{AWIDTH{1'b0}}, accept};
        wcol     <= '0;
        wbank    <= ~wbank;
      end else if (accept) begin
        wcol <= wcol + COL_ONE;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read sequencer: state register / next-state / outputs
  // -------------------------------------------------------------------------
  state_t          state, state_nx;
  logic [7:0]      hcnt, hcnt_nx;
  logic [AWIDTH:0] rcol, rcol_nx;
  logic            rep, rep_nx;
  logic            rbank;
  logic            emit_hs, emit_de;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      hcnt  <= '0;
      rcol  <= '0;
      rep   <= 1'b0;
      rbank <= 1'b0;
    end else begin
      state <= state_nx;
      hcnt  <= hcnt_nx;
      rcol  <= rcol_nx;
      rep   <= rep_nx;
      if (line_end) begin
        rbank <= wbank;
      end
    end
  end

  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    rcol_nx  = rcol;
    rep_nx   = rep;
    if (line_end) begin
      // A new line always wins: any replay in progress is abandoned.
      state_nx = S_HS;
      hcnt_nx  = '0;
      rcol_nx  = '0;
      rep_nx   = 1'b0;
    end else if (ce_out) begin
      case (state)
        S_IDLE: begin
          state_nx = S_IDLE;
        end
        S_HS: begin
          hcnt_nx = hcnt + 8'd1;
          if (hcnt == HS_LAST) begin
            hcnt_nx = '0;
            rcol_nx = '0;
            if (line_len != '0) begin
              state_nx = S_ACTIVE;
            end else if (!rep) begin
              // Empty line: go straight to the repeat decision.
              rep_nx   = 1'b1;
              state_nx = S_HS;
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
        S_ACTIVE: begin
          rcol_nx = rcol + COL_ONE;
          if (rcol + COL_ONE == line_len) begin
            rcol_nx = '0;
            if (!rep) begin
              rep_nx   = 1'b1;
              state_nx = S_HS;
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    emit_hs       = 1'b0;
    emit_de       = 1'b0;
    buf_rdaddress = '0;
    case (state)
      S_HS: begin
        emit_hs = 1'b1;
      end
      S_ACTIVE: begin
        emit_de       = 1'b1;
        buf_rdaddress = {rbank, rcol[AWIDTH-1:0]};
      end
      default: begin
        emit_hs = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output pipeline. Stage 1 is captured on the edge where the RAM samples
  // buf_rdaddress; stage 2 captures buf_q on the following edge, when the
  // RAM's registered read data for that address is available.
  // -------------------------------------------------------------------------
  logic s1_v, s1_hs, s1_de;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_v    <= 1'b0;
      s1_hs   <= 1'b0;
      s1_de   <= 1'b0;
      hs_out  <= 1'b0;
      de_out  <= 1'b0;
      pix_out <= '0;
    end else begin
      s1_v  <= ce_out;
      s1_hs <= ce_out & emit_hs;
      s1_de <= ce_out & emit_de;
      if (s1_v) begin
        hs_out  <= s1_hs;
        de_out  <= s1_de;
        pix_out <= s1_de ? buf_q : '0;
      end
    end
  end

endmodule
